// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding-select generation for the 5-stage MIPS pipeline.
// Tracks the destination registers of the instructions in EX and MEM and compares
// them against the sources of the instruction in ID. It drives a same-cycle load-use
// stall and registered forward selects that reach EX together with the instruction.
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_writes_reg,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_is_load,
    input  logic                  ex_flush,
    output logic                  stall,
    output logic [1:0]            fwda,
    output logic [1:0]            fwdb,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EX  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;

    // Pipeline tracking state: instruction now in EX and instruction now in MEM.
    logic                  r_ex_v;
    logic [REG_ADDR_W-1:0] r_ex_dest;
    logic                  r_ex_load;
    logic                  r_mem_v;
    logic [REG_ADDR_W-1:0] r_mem_dest;
    logic [1:0]            r_fwda;
    logic [1:0]            r_fwdb;
    logic [CNT_W-1:0]      r_stall_count;
    logic [CNT_W-1:0]      r_flush_count;

    logic                  w_haz;
    logic                  w_stall;
    logic                  w_advance;
    logic                  w_ex_v_nxt;
    logic [1:0]            w_fwda_nxt;
    logic [1:0]            w_fwdb_nxt;

    // Forward select for one source: youngest tracked producer wins, r0 never matches.
    function automatic logic [1:0] fwd_sel(
        input logic                  use_src,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  ex_v,
        input logic [REG_ADDR_W-1:0] ex_dest,
        input logic                  mem_v,
        input logic [REG_ADDR_W-1:0] mem_dest
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (!use_src || (src == REG_ZERO)) begin
            sel = SEL_RF;
        end else if (ex_v && (src == ex_dest)) begin
            sel = SEL_EX;
        end else if (mem_v && (src == mem_dest)) begin
            sel = SEL_MEM;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    // Load-use hazard, stall (flush wins), and the next EX-stage tracking/select values.
    always_comb begin
        w_haz = id_valid && r_ex_v && r_ex_load &&
                ((id_uses_rs && (id_rs != REG_ZERO) && (id_rs == r_ex_dest)) ||
                 (id_uses_rt && (id_rt != REG_ZERO) && (id_rt == r_ex_dest)));
        w_stall    = w_haz && !ex_flush;
        w_advance  = id_valid && !w_stall && !ex_flush;
        w_ex_v_nxt = w_advance && id_writes_reg && (id_dest != REG_ZERO);
        if (w_advance) begin
            w_fwda_nxt = fwd_sel(id_uses_rs, id_rs, r_ex_v, r_ex_dest, r_mem_v, r_mem_dest);
            w_fwdb_nxt = fwd_sel(id_uses_rt, id_rt, r_ex_v, r_ex_dest, r_mem_v, r_mem_dest);
        end else begin
            w_fwda_nxt = SEL_RF;
            w_fwdb_nxt = SEL_RF;
        end
    end

    // Advance the EX/MEM tracking state and register the selects for the next EX cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_v     <= 1'b0;
            r_ex_dest  <= REG_ZERO;
            r_ex_load  <= 1'b0;
            r_mem_v    <= 1'b0;
            r_mem_dest <= REG_ZERO;
            r_fwda     <= SEL_RF;
            r_fwdb     <= SEL_RF;
        end else begin
            r_mem_v    <= r_ex_v;
            r_mem_dest <= r_ex_dest;
            r_ex_v     <= w_ex_v_nxt;
            r_ex_dest  <= w_ex_v_nxt ? id_dest : REG_ZERO;
            r_ex_load  <= w_ex_v_nxt && id_is_load;
            r_fwda     <= w_fwda_nxt;
            r_fwdb     <= w_fwdb_nxt;
        end
    end

    // Saturating event counters for load-use stall cycles and flushed ID instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end else begin
                r_stall_count <= r_stall_count;
            end
            if (ex_flush && id_valid && (r_flush_count != {CNT_W{1'b1}})) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end else begin
                r_flush_count <= r_flush_count;
            end
        end
    end

    assign stall       = w_stall;
    assign fwda        = r_fwda;
    assign fwdb        = r_fwdb;
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule
